fmul_add_norm_stage: RTL and testbench

- Consumer ("reader") side of the partial-multiply-to-addition pipeline register in the pipelined FP32 multiplier.
- Takes the registered carry-save bundle (`a_*` signals) and performs the final carry-propagate add.
- Normalizes, rounds per `a_rm`, handles denormal/overflow/NaN/Inf, and packs the IEEE-754 single result.
- Two internal pipeline stages with valid/ready handshake on both sides, so the multiplier can be back-pressured by the FP writeback path.

---
 rtl/fmul_add_norm_stage_if.sv | 39 +++
 rtl/fmul_add_norm_stage.sv | 210 +++++++++++++++++++++
 tb/tb_fmul_add_norm_stage.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_add_norm_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fmul_add_norm_stage_if
// Description : Handshake bundle between the carry-save multiply register and
//               the add/normalize/round stage, plus the packed result side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fmul_add_norm_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  a_rm;
    logic        a_sign;
    logic [9:0]  a_exp10;
    logic        a_is_nan;
    logic        a_is_inf;
    logic [22:0] a_inf_nan_frac;
    logic [39:0] a_sum;
    logic [39:0] a_carry;
    logic [7:0]  a_z8;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    // Producer of bundles and consumer of results
    modport master (
        output in_valid, a_rm, a_sign, a_exp10, a_is_nan, a_is_inf,
               a_inf_nan_frac, a_sum, a_carry, a_z8, out_ready,
        input  in_ready, out_valid, result, flags
    );

    // The add/normalize/round stage itself
    modport slave (
        input  in_valid, a_rm, a_sign, a_exp10, a_is_nan, a_is_inf,
               a_inf_nan_frac, a_sum, a_carry, a_z8, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface
`default_nettype wire

// File: rtl/fmul_add_norm_stage.sv
`default_nettype none
// ============================================================================
// Module      : fmul_add_norm_stage
// Description : Final carry-propagate add of the FP32 multiplier carry-save
//               product, followed by normalization, rounding, special-case
//               handling and IEEE-754 single packing. Two registered stages
//               with valid/ready flow control on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_add_norm_stage #(
    parameter int DENORM_EN = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    fmul_add_norm_stage_if.slave  bus
);

    localparam logic [1:0] c_rm_rne    = 2'b00;
    localparam logic [1:0] c_rm_rdn    = 2'b01;
    localparam logic [1:0] c_rm_rup    = 2'b10;
    localparam logic [1:0] c_rm_rtz    = 2'b11;
    localparam logic       c_denorm_en = (DENORM_EN != 0);

    // Stage 1 state: normalized mantissa with guard/sticky and passthrough
    logic        s1_valid_q,  s1_valid_d;
    logic [23:0] s1_mant_q,   s1_mant_d;
    logic [9:0]  s1_exp_q,    s1_exp_d;
    logic        s1_guard_q,  s1_guard_d;
    logic        s1_sticky_q, s1_sticky_d;
    logic [1:0]  s1_rm_q,     s1_rm_d;
    logic        s1_sign_q,   s1_sign_d;
    logic        s1_nan_q,    s1_nan_d;
    logic        s1_inf_q,    s1_inf_d;
    logic [22:0] s1_frac_q,   s1_frac_d;

    // Stage 2 state: packed result
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q,    result_d;
    logic [2:0]  flags_q,     flags_d;

    logic        s1_moves;
    logic        in_fire;

    // Stage 1 may advance whenever the output register is empty or draining
    assign s1_moves      = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = !s1_valid_q || s1_moves;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    logic [39:0] z_hi;
    logic [47:0] z48;

    // Stage 1: resolve carry-save, pick the leading-one position, gather g/s
    always_comb begin
        z_hi        = bus.a_sum + bus.a_carry;
        z48         = {z_hi, bus.a_z8};
        s1_valid_d  = s1_valid_q;
        s1_mant_d   = s1_mant_q;
        s1_exp_d    = s1_exp_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_rm_d     = s1_rm_q;
        s1_sign_d   = s1_sign_q;
        s1_nan_d    = s1_nan_q;
        s1_inf_d    = s1_inf_q;
        s1_frac_d   = s1_frac_q;
        if (bus.in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_fire) begin
            if (z48[47]) begin
                s1_mant_d   = z48[47:24];
                s1_exp_d    = bus.a_exp10 + 10'd1;
                s1_guard_d  = z48[23];
                s1_sticky_d = |z48[22:0];
            end else begin
                s1_mant_d   = z48[46:23];
                s1_exp_d    = bus.a_exp10;
                s1_guard_d  = z48[22];
                s1_sticky_d = |z48[21:0];
            end
            s1_rm_d   = bus.a_rm;
            s1_sign_d = bus.a_sign;
            s1_nan_d  = bus.a_is_nan;
            s1_inf_d  = bus.a_is_inf;
            s1_frac_d = bus.a_inf_nan_frac;
        end
    end

    logic signed [10:0] exp_x;
    logic signed [10:0] exp_fin;
    logic        [10:0] sh_raw;
    logic        [4:0]  sh;
    logic        [50:0] wide;
    logic        [23:0] rnd_mant;
    logic               rnd_guard;
    logic               rnd_sticky;
    logic               inc;
    logic               inexact;
    logic               is_low;
    logic        [24:0] mant_r;
    logic        [31:0] res;
    logic        [2:0]  flg;

    // Stage 2: denormalize if needed, round, detect overflow, pack
    always_comb begin
        exp_x  = $signed({s1_exp_q[9], s1_exp_q});
        is_low = (exp_x < 11'sd1);
        // Anything beyond 26 places leaves only sticky, so saturate there
        sh_raw = 11'd1 - exp_x;
        sh     = (sh_raw > 11'd26) ? 5'd26 : sh_raw[4:0];
        wide   = {s1_mant_q, s1_guard_q, 26'd0} >> sh;

        if (is_low) begin
            rnd_mant   = wide[50:27];
            rnd_guard  = wide[26];
            rnd_sticky = s1_sticky_q | (|wide[25:0]);
        end else begin
            rnd_mant   = s1_mant_q;
            rnd_guard  = s1_guard_q;
            rnd_sticky = s1_sticky_q;
        end

        case (s1_rm_q)
            c_rm_rne: inc = rnd_guard && (rnd_sticky || rnd_mant[0]);
            c_rm_rdn: inc = s1_sign_q && (rnd_guard || rnd_sticky);
            c_rm_rup: inc = !s1_sign_q && (rnd_guard || rnd_sticky);
            c_rm_rtz: inc = 1'b0;
            default:  inc = 1'b0;
        endcase
        inexact = rnd_guard || rnd_sticky;
        mant_r  = {1'b0, rnd_mant} + {24'd0, inc};
        // A carry out of the hidden bit leaves mant_r[23:0] all zero (1.0)
        exp_fin = exp_x + (mant_r[24] ? 11'sd1 : 11'sd0);

        res = 32'd0;
        flg = 3'b000;
        if (s1_nan_q || s1_inf_q) begin
            res = {s1_sign_q, 8'hFF, s1_frac_q};
        end else if (s1_mant_q == 24'd0) begin
            res = {s1_sign_q, 31'd0};
        end else if (is_low && !c_denorm_en) begin
            res = {s1_sign_q, 31'd0};
            flg = 3'b011;
        end else if (is_low) begin
            // Rounding up to 2^23 spills into the exponent LSB: min normal
            res = {s1_sign_q, 7'd0, mant_r[23:0]};
            flg = {1'b0, inexact, inexact};
        end else if (exp_fin >= 11'sd255) begin
            flg = 3'b101;
            case (s1_rm_q)
                c_rm_rne: res = {s1_sign_q, 31'h7F800000};
                c_rm_rdn: res = s1_sign_q ? 32'hFF800000 : 32'h7F7FFFFF;
                c_rm_rup: res = s1_sign_q ? 32'hFF7FFFFF : 32'h7F800000;
                default:  res = {s1_sign_q, 31'h7F7FFFFF};
            endcase
        end else begin
            res = {s1_sign_q, exp_fin[7:0], mant_r[22:0]};
            flg = {2'b00, inexact};
        end

        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (s1_moves) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = res;
                flags_d  = flg;
            end
        end
    end

    // Pipeline registers; reset drops all in-flight operations
    always_ff @(posedge clk) begin
        if (clr) begin
            s1_valid_q  <= 1'b0;
            s1_mant_q   <= 24'd0;
            s1_exp_q    <= 10'd0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_rm_q     <= 2'b00;
            s1_sign_q   <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_frac_q   <= 23'd0;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            flags_q     <= 3'b000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mant_q   <= s1_mant_d;
            s1_exp_q    <= s1_exp_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_rm_q     <= s1_rm_d;
            s1_sign_q   <= s1_sign_d;
            s1_nan_q    <= s1_nan_d;
            s1_inf_q    <= s1_inf_d;
            s1_frac_q   <= s1_frac_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmul_add_norm_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmul_add_norm_stage
// Description : Scoreboard bench for fmul_add_norm_stage; one instance with
//               subnormal support and one that flushes underflow to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_add_norm_stage;

    typedef struct packed {
        logic [1:0]  rm;
        logic        sign;
        logic [9:0]  ex;
        logic        nan;
        logic        inf;
        logic [22:0] frac;
        logic [39:0] sum;
        logic [39:0] carry;
        logic [7:0]  z8;
    } bundle_t;

    logic    clk = 1'b0;
    logic    clr;
    logic    in_valid;
    logic    out_ready;
    bit      rand_ready;
    bundle_t drv;

    always #5 clk = ~clk;

    fmul_add_norm_stage_if if0 ();
    fmul_add_norm_stage_if if1 ();

    assign if0.in_valid       = in_valid;   assign if1.in_valid       = in_valid;
    assign if0.out_ready      = out_ready;  assign if1.out_ready      = out_ready;
    assign if0.a_rm           = drv.rm;     assign if1.a_rm           = drv.rm;
    assign if0.a_sign         = drv.sign;   assign if1.a_sign         = drv.sign;
    assign if0.a_exp10        = drv.ex;     assign if1.a_exp10        = drv.ex;
    assign if0.a_is_nan       = drv.nan;    assign if1.a_is_nan       = drv.nan;
    assign if0.a_is_inf       = drv.inf;    assign if1.a_is_inf       = drv.inf;
    assign if0.a_inf_nan_frac = drv.frac;   assign if1.a_inf_nan_frac = drv.frac;
    assign if0.a_sum          = drv.sum;    assign if1.a_sum          = drv.sum;
    assign if0.a_carry        = drv.carry;  assign if1.a_carry        = drv.carry;
    assign if0.a_z8           = drv.z8;     assign if1.a_z8           = drv.z8;

    fmul_add_norm_stage #(.DENORM_EN(1)) dut0 (.clk(clk), .clr(clr), .bus(if0));
    fmul_add_norm_stage #(.DENORM_EN(0)) dut1 (.clk(clk), .clr(clr), .bus(if1));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [34:0] q0[$];
    logic [34:0] q1[$];
    bit          held [2];
    logic [34:0] hold [2];

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Reference: keep as many significant bits as the target format allows,
    // then round the discarded remainder according to the mode.
    function automatic logic [34:0] model(input bundle_t b, input bit den);
        logic [39:0] hi;
        logic [63:0] z, q;
        logic [31:0] res;
        int          p, e, keep, drop;
        bit          g, st, inc, inx;
        if (b.nan || b.inf) return {3'b000, b.sign, 8'hFF, b.frac};
        hi = b.sum + b.carry;
        z  = {16'd0, hi, b.z8};
        p  = z[47] ? 47 : 46;
        e  = int'($signed(b.ex)) + (z[47] ? 1 : 0);
        if ((z >> (p - 23)) == 64'd0) return {3'b000, b.sign, 31'd0};
        if (e <= 0 && !den) return {3'b011, b.sign, 31'd0};
        keep = (e <= 0) ? 23 + e : 24;
        drop = p + 1 - keep;
        if (drop > 48) begin
            q = 64'd0; g = 1'b0; st = 1'b1;
        end else begin
            q  = z >> drop;
            g  = z[drop-1];
            st = (z & ((64'd1 << (drop - 1)) - 64'd1)) != 64'd0;
        end
        case (b.rm)
            2'd0:    inc = g && (st || q[0]);
            2'd1:    inc = b.sign && (g || st);
            2'd2:    inc = !b.sign && (g || st);
            default: inc = 1'b0;
        endcase
        inx = g || st;
        q   = q + 64'(inc);
        if (e <= 0) return {1'b0, inx, inx, b.sign, q[30:0]};
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) begin
            case (b.rm)
                2'd0:    res = {b.sign, 31'h7F800000};
                2'd1:    res = b.sign ? 32'hFF800000 : 32'h7F7FFFFF;
                2'd2:    res = b.sign ? 32'hFF7FFFFF : 32'h7F800000;
                default: res = {b.sign, 31'h7F7FFFFF};
            endcase
            return {3'b101, res};
        end
        return {2'b00, inx, b.sign, 8'(e), q[22:0]};
    endfunction

    function automatic bundle_t mk(input logic [1:0] rm, input logic sign, input logic [9:0] ex,
                                   input logic nan, input logic [22:0] frac,
                                   input logic [39:0] sum, input logic [39:0] carry);
        bundle_t b;
        b.rm = rm; b.sign = sign; b.ex = ex; b.nan = nan; b.inf = 1'b0;
        b.frac = frac; b.sum = sum; b.carry = carry; b.z8 = 8'd0;
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t     b;
        logic [23:0] ma, mb;
        logic [47:0] p;
        logic [39:0] r;
        ma = {1'b1, 23'($urandom)};
        mb = ($urandom_range(0, 3) == 0) ? 24'h800000 : {1'b1, 23'($urandom)};
        p  = {24'd0, ma} * {24'd0, mb};
        if ($urandom_range(0, 7) == 0) p = {16'($urandom), 32'($urandom)};
        r       = {8'($urandom), 32'($urandom)};
        b.sum   = r;
        b.carry = p[47:8] - r;
        b.z8    = p[7:0];
        b.ex    = 10'(int'($urandom_range(0, 330)) - 50);
        b.rm    = 2'($urandom);
        b.sign  = 1'($urandom);
        b.nan   = ($urandom_range(0, 19) == 0);
        b.inf   = !b.nan && ($urandom_range(0, 19) == 0);
        b.frac  = 23'($urandom);
        return b;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input bundle_t b, input bit fixed, input logic [34:0] e0, input logic [34:0] e1);
        int budget;
        bit acc;
        drv      = b;
        in_valid = 1'b1;
        budget   = 0;
        acc      = 1'b0;
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = if0.in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        if (acc) begin
            q0.push_back(fixed ? e0 : model(b, 1'b1));
            q1.push_back(fixed ? e1 : model(b, 1'b0));
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0) && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d results outstanding, expected 0", q0.size(), q1.size());
        end
    endtask

    task automatic mon(input int k, input logic ov, input logic ordy, input logic [34:0] data);
        logic [34:0] want;
        bit          empty;
        if (held[k]) begin
            check(k == 0 ? "hold_valid0" : "hold_valid1", {34'd0, ov}, 35'd1);
            check(k == 0 ? "hold_data0" : "hold_data1", data, hold[k]);
        end
        if (ov && ordy) begin
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output%0d: got %h, expected no output", k, data);
            end else begin
                want = (k == 0) ? q0.pop_front() : q1.pop_front();
                check(k == 0 ? "result_den1" : "result_den0", data, want);
            end
        end
        held[k] = ov && !ordy;
        hold[k] = data;
    endtask

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (clr) begin
            held[0] = 1'b0;
            held[1] = 1'b0;
        end else begin
            mon(0, if0.out_valid, out_ready, {if0.flags, if0.result});
            mon(1, if1.out_valid, out_ready, {if1.flags, if1.result});
        end
    end

    // Random back-pressure when enabled
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bundle_t       b;
        logic [31:0]   ovf_exp [4];
        ovf_exp[0] = 32'hFF800000; ovf_exp[1] = 32'hFF800000;
        ovf_exp[2] = 32'hFF7FFFFF; ovf_exp[3] = 32'hFF7FFFFF;
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rand_ready = 1'b0; drv = '0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;

        @(negedge clk);
        check("rst_out_valid", {33'd0, if0.out_valid, if1.out_valid}, 35'd0);
        check("rst_result0", {if0.flags, if0.result}, 35'd0);
        check("rst_result1", {if1.flags, if1.result}, 35'd0);
        check("rst_in_ready", {33'd0, if0.in_ready, if1.in_ready}, 35'd3);
        @(posedge clk);
        #1;

        // 1.5 x 1.5
        b = mk(2'b00, 1'b0, 10'd127, 1'b0, 23'd0, 40'h8000000000, 40'h1000000000);
        send(b, 1'b1, {3'b000, 32'h40100000}, {3'b000, 32'h40100000});
        // Overflow in every rounding mode
        for (int m = 0; m < 4; m++) begin
            b = mk(2'(m), 1'b1, 10'd254, 1'b0, 23'd0, 40'h8000000000, 40'd0);
            send(b, 1'b1, {3'b101, ovf_exp[m]}, {3'b101, ovf_exp[m]});
        end
        // NaN ignores the carry-save data
        b = mk(2'b00, 1'b0, 10'd5, 1'b1, 23'h400000, 40'h123456789A, 40'hFEDCBA9876);
        send(b, 1'b1, {3'b000, 32'h7FC00000}, {3'b000, 32'h7FC00000});
        // Subnormal vs flush
        b = mk(2'b00, 1'b0, 10'h3FF, 1'b0, 23'd0, 40'h4000000000, 40'd0);
        send(b, 1'b1, {3'b000, 32'h00200000}, {3'b011, 32'h00000000});
        drain();

        // Back-pressure: four back-to-back bundles, output stalled 5 cycles
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(rand_bundle(), 1'b0, 35'd0, 35'd0);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", {33'd0, if0.in_ready, if1.in_ready}, 35'd0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight and a third presented
        out_ready = 1'b0;
        send(rand_bundle(), 1'b0, 35'd0, 35'd0);
        send(rand_bundle(), 1'b0, 35'd0, 35'd0);
        clr      = 1'b1;
        drv      = rand_bundle();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check("mid_rst_out_valid", {33'd0, if0.out_valid, if1.out_valid}, 35'd0);
        check("mid_rst_result0", {if0.flags, if0.result}, 35'd0);
        check("mid_rst_result1", {if1.flags, if1.result}, 35'd0);
        check("mid_rst_in_ready", {33'd0, if0.in_ready, if1.in_ready}, 35'd3);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(rand_bundle(), 1'b0, 35'd0, 35'd0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
